// File: rtl/dds_pkg.sv
// Shared constants, quadrant type and quarter-wave table formula for the
// DDS phase-to-sine converter. The ROM initialisation and any software or
// bench model draw table entries from quarter_sine() so they cannot diverge.
package dds_pkg;

    localparam int PHASE_W   = 28;
    localparam int LUT_AW    = 8;
    localparam int AMP_W     = 12;
    localparam int LUT_DEPTH = 1 << LUT_AW;
    localparam int AMP_MAX   = (1 << (AMP_W - 1)) - 1;

    typedef enum logic [1:0] {
        Q_RISE_POS = 2'd0,
        Q_FALL_POS = 2'd1,
        Q_FALL_NEG = 2'd2,
        Q_RISE_NEG = 2'd3
    } quad_e;

    // Entry k samples the first quarter wave at the centre of bin k. The
    // half-step keeps the mirrored quadrants exact and keeps the peak just
    // below AMP_MAX + 0.5, so every entry fits and negation cannot overflow.
    function automatic logic [AMP_W-2:0] quarter_sine(input int k);
        real pi;
        real x;
        real y;
        pi = 3.14159265358979323846;
        x  = (pi / 2.0) * (real'(k) + 0.5) / real'(LUT_DEPTH);
        y  = real'(AMP_MAX) * $sin(x);
        return (AMP_W - 1)'($rtoi(y + 0.5));
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine ROM: LUT_DEPTH x (AMP_W-1) unsigned magnitudes with a
// registered read (one cycle latency).
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (output register only)
//   i_addr   table index
//   o_data   registered table entry
module sine_quarter_rom
    import dds_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [LUT_AW-1:0] i_addr,
    output logic [AMP_W-2:0]  o_data
);

    // Constant table; contents are fixed at elaboration time.
    logic [AMP_W-2:0] w_table [LUT_DEPTH];
    logic [AMP_W-2:0] r_data;

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_table
        assign w_table[k] = quarter_sine(k);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= w_table[i_addr];
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/dds_phase_to_sine.sv
// Phase-to-amplitude converter for a DDS. Adds a phase offset, folds the
// phase into a quarter-wave table lookup and restores sign/mirroring per
// quadrant. Fixed 4-cycle latency, valid-tagged, no stalls.
// Ports:
//   CLOCK_50      rising-edge clock
//   reset         asynchronous active-low reset
//   phase_in      unsigned accumulator phase, full scale = one cycle
//   in_valid      qualifies phase_in / phase_offset
//   phase_offset  unsigned phase offset, added modulo 2^PHASE_W
//   sine_out      signed sample, loads only on valid, otherwise holds
//   out_valid     one pulse per accepted input, 4 cycles later
module dds_phase_to_sine
    import dds_pkg::*;
(
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [PHASE_W-1:0]       phase_in,
    input  logic                     in_valid,
    input  logic [PHASE_W-1:0]       phase_offset,
    output logic signed [AMP_W-1:0]  sine_out,
    output logic                     out_valid
);

    localparam int TOP_W = LUT_AW + 2;

    function automatic logic is_mirrored(input quad_e q);
        return (q == Q_FALL_POS) || (q == Q_RISE_NEG);
    endfunction

    function automatic logic is_negative(input quad_e q);
        return (q == Q_FALL_NEG) || (q == Q_RISE_NEG);
    endfunction

    // Table peak is below 2^(AMP_W-1), so negation always fits.
    function automatic logic signed [AMP_W-1:0] apply_sign(input quad_e q,
                                                           input logic [AMP_W-2:0] mag);
        logic signed [AMP_W-1:0] m;
        m = $signed({1'b0, mag});
        return is_negative(q) ? -m : m;
    endfunction

    logic [PHASE_W-1:0]      w_sum;
    logic                    w_unused_lsbs;
    logic [TOP_W-1:0]        r_phase_p1;
    logic                    r_vld_p1;
    quad_e                   w_quad_p1;
    logic [LUT_AW-1:0]       w_addr_p1;
    logic [LUT_AW-1:0]       r_idx_p2;
    quad_e                   r_quad_p2;
    logic                    r_vld_p2;
    logic [AMP_W-2:0]        w_mag_p3;
    quad_e                   r_quad_p3;
    logic                    r_vld_p3;
    logic signed [AMP_W-1:0] r_sine_p4;
    logic                    r_vld_p4;

    // Modulo add: the carry-out is simply dropped. Bits below the table
    // resolution are truncated, so only the top bits are registered.
    assign w_sum         = phase_in + phase_offset;
    assign w_unused_lsbs = ^w_sum[PHASE_W-TOP_W-1:0];

    // ---- stage 1: offset-added phase ----
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_phase_p1 <= '0;
            r_vld_p1   <= 1'b0;
        end else begin
            r_phase_p1 <= w_sum[PHASE_W-1 -: TOP_W];
            r_vld_p1   <= in_valid;
        end
    end

    assign w_quad_p1 = quad_e'(r_phase_p1[TOP_W-1 -: 2]);
    assign w_addr_p1 = r_phase_p1[LUT_AW-1:0];

    // ---- stage 2: quadrant split and mirrored table index ----
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_idx_p2  <= '0;
            r_quad_p2 <= Q_RISE_POS;
            r_vld_p2  <= 1'b0;
        end else begin
            r_idx_p2  <= is_mirrored(w_quad_p1) ? ~w_addr_p1 : w_addr_p1;
            r_quad_p2 <= w_quad_p1;
            r_vld_p2  <= r_vld_p1;
        end
    end

    // ---- stage 3: ROM read, quadrant delayed alongside ----
    sine_quarter_rom u_rom (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset),
        .i_addr  (r_idx_p2),
        .o_data  (w_mag_p3)
    );

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_quad_p3 <= Q_RISE_POS;
            r_vld_p3  <= 1'b0;
        end else begin
            r_quad_p3 <= r_quad_p2;
            r_vld_p3  <= r_vld_p2;
        end
    end

    // ---- stage 4: sign restore; sample holds across bubbles ----
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_sine_p4 <= '0;
            r_vld_p4  <= 1'b0;
        end else begin
            if (r_vld_p3) begin
                r_sine_p4 <= apply_sign(r_quad_p3, w_mag_p3);
            end
            r_vld_p4 <= r_vld_p3;
        end
    end

    assign sine_out  = r_sine_p4;
    assign out_valid = r_vld_p4;

endmodule

// File: tb/tb_dds_phase_to_sine.sv
module tb_dds_phase_to_sine;
    import dds_pkg::*;

    localparam logic [PHASE_W-1:0] STEP = PHASE_W'(32'h0040000);

    logic                    CLOCK_50     = 1'b0;
    logic                    reset        = 1'b0;
    logic                    in_valid     = 1'b0;
    logic [PHASE_W-1:0]      phase_in     = '0;
    logic [PHASE_W-1:0]      phase_offset = '0;
    logic signed [AMP_W-1:0] sine_out;
    logic                    out_valid;

    dds_phase_to_sine dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .phase_in     (phase_in),
        .in_valid     (in_valid),
        .phase_offset (phase_offset),
        .sine_out     (sine_out),
        .out_valid    (out_valid)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        bit v;
        int val;
    } exp_t;

    int   n_vec    = 0;
    int   n_err    = 0;
    exp_t pend[$];
    int   last_val = 0;
    bit   rec      = 1'b0;
    int   samp[$];

    // Reference: one full sine cycle over 2^PHASE_W, quantised to
    // 4*LUT_DEPTH bins, quarter_sine gives the first-quadrant magnitude.
    function automatic int model(input logic [PHASE_W-1:0] ph,
                                 input logic [PHASE_W-1:0] off);
        logic [PHASE_W-1:0] s;
        int k, quad, idx, v;
        s    = ph + off;
        k    = int'(s >> (PHASE_W - LUT_AW - 2));
        quad = k / LUT_DEPTH;
        idx  = k % LUT_DEPTH;
        if (quad == 1 || quad == 3) idx = LUT_DEPTH - 1 - idx;
        v = int'(quarter_sine(idx));
        return (quad >= 2) ? -v : v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: check the output due from 4 cycles ago, then drive.
    task automatic cycle(input bit v, input logic [PHASE_W-1:0] ph,
                         input logic [PHASE_W-1:0] off);
        exp_t e;
        int   ev;
        @(negedge CLOCK_50);
        reset = 1'b1;
        if (pend.size() == 4) begin
            e  = pend.pop_front();
            ev = e.v ? e.val : last_val;
            chk("out_valid", int'(out_valid), int'(e.v));
            chk("sine_out", int'(sine_out), ev);
            last_val = ev;
            if (rec && e.v) samp.push_back(int'(sine_out));
        end
        in_valid     = v;
        phase_in     = ph;
        phase_offset = off;
        e.v   = v;
        e.val = model(ph, off);
        pend.push_back(e);
    endtask

    task automatic flush();
        repeat (4) cycle(1'b0, PHASE_W'($urandom()), PHASE_W'($urandom()));
    endtask

    // Reset asserted away from the active edge; outputs must clear at once.
    task automatic rst_pulse(input int ncyc);
        exp_t e;
        @(negedge CLOCK_50);
        reset    = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sine", int'(sine_out), 0);
        for (int i = 1; i < ncyc; i++) begin
            @(negedge CLOCK_50);
            chk("rst_valid_hold", int'(out_valid), 0);
            chk("rst_sine_hold", int'(sine_out), 0);
        end
        pend.delete();
        last_val = 0;
        e.v   = 1'b0;
        e.val = 0;
        repeat (4) pend.push_back(e);
    endtask

    task automatic pulse(input string tag, input logic [PHASE_W-1:0] ph,
                         input logic [PHASE_W-1:0] off, input int exp);
        cycle(1'b1, ph, off);
        flush();
        chk(tag, int'(sine_out), exp);
    endtask

    initial begin
        logic [PHASE_W-1:0] ph;

        rst_pulse(3);

        pulse("q0_start", PHASE_W'(32'h0000000), '0, 6);
        pulse("q1_start", PHASE_W'(32'h4000000), '0, 2047);
        pulse("q2_start", PHASE_W'(32'h8000000), '0, -6);
        pulse("q3_start", PHASE_W'(32'hC000000), '0, -2047);

        pulse("off_wrap0", PHASE_W'(32'hC000000), PHASE_W'(32'h4000000), 6);
        pulse("off_wrap1", PHASE_W'(32'hC000000), PHASE_W'(32'h8000000), 2047);

        pulse("trunc_hi", PHASE_W'(32'h003FFFF), '0, 6);
        pulse("trunc_lo", PHASE_W'(32'h0000000), '0, 6);
        pulse("trunc_k1", PHASE_W'(32'h0040000), '0, 19);

        // Full-cycle sweep, one table step per cycle.
        rec = 1'b1;
        ph  = '0;
        for (int i = 0; i < 1024; i++) begin
            cycle(1'b1, ph, '0);
            ph = ph + STEP;
        end
        flush();
        rec = 1'b0;
        chk("sweep_len", samp.size(), 1024);
        if (samp.size() == 1024) begin
            for (int n = 0; n < 512; n++) begin
                chk("sym_mirror", samp[n], samp[511-n]);
                chk("sym_negate", samp[n+512], -samp[n]);
            end
            for (int n = 0; n < 1024; n++) begin
                chk("no_min", (samp[n] == -2048) ? 1 : 0, 0);
            end
        end

        // Bubble pattern 1,0,1,1,0.
        cycle(1'b1, PHASE_W'($urandom()), '0);
        cycle(1'b0, PHASE_W'($urandom()), '0);
        cycle(1'b1, PHASE_W'($urandom()), '0);
        cycle(1'b1, PHASE_W'($urandom()), '0);
        cycle(1'b0, PHASE_W'($urandom()), '0);
        flush();

        // Reset in the middle of a sweep.
        ph = '0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, ph, '0);
            ph = ph + STEP;
        end
        rst_pulse(2);
        for (int i = 10; i < 60; i++) begin
            cycle(1'b1, ph, '0);
            ph = ph + STEP;
        end
        flush();

        // Random phases, offsets and valid pattern.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), PHASE_W'($urandom()), PHASE_W'($urandom()));
        end
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dds_phase_to_sine.md
Name: dds_phase_to_sine

Overview:
Phase-to-amplitude converter that consumes the 28-bit phase word from the DDS phase accumulator and produces a signed sine sample. It uses a quarter-wave lookup table with quadrant mirroring and negation, in a fixed-latency, valid-tagged pipeline with no stalls. An additive phase offset supports phase shifting and quadrature (I/Q) pairs. The output feeds the DAC or audio output stage directly.

Parameters:
PHASE_W, 28, width of the phase_in and phase_offset words.
LUT_AW, 8, quarter-table address bits. The top LUT_AW+2 phase bits are used and the rest are truncated.
AMP_W, 12, signed output sample width.

Ports:
CLOCK_50  input  1  system clock; all logic is on its rising edge.
reset  input  1  asynchronous, active-low reset.
phase_in  input  PHASE_W  accumulator phase, unsigned; 0 to 2^PHASE_W-1 spans one full cycle.
in_valid  input  1  qualifies phase_in. Tie to 1 for continuous operation.
phase_offset  input  PHASE_W  unsigned phase offset, added modulo 2^PHASE_W. Sampled together with phase_in.
sine_out  output  AMP_W  signed two's-complement sample.
out_valid  output  1  high for one cycle for each accepted input.

Behaviour:
- Reset, while reset is low:
  - all pipeline valid bits = 0, out_valid = 0, sine_out = 0, all data registers = 0.
  - Deassertion takes effect on the next clock edge.
- Reset mid-operation: in-flight samples are discarded, not completed. The first out_valid after release comes 4 cycles after the first in_valid sampled post-release.
- Pipeline structure:
  - Four register stages; latency is exactly 4 cycles from in_valid to out_valid.
  - A valid bit travels with each sample. There is no backpressure and no stall.
  - Back-to-back inputs give back-to-back outputs at a throughput of 1 per cycle.
- S1: p1 = (phase_in + phase_offset) mod 2^PHASE_W. The carry-out is dropped, so the sum wraps silently.
- S2: take the top LUT_AW+2 bits of p1.
  - q = the top 2 bits (quadrant).
  - a = the next LUT_AW bits.
  - If q[0] = 1, the index is (2^LUT_AW-1) - a, i.e. bitwise ~a. Otherwise the index is a.
  - Register the index and q.
- S3: synchronous ROM read of the quarter table at the index; q is delayed alongside.
- S4: sine_out = q[1] ? -rom : rom.
  - sine_out loads only when the S3 valid bit is 1; otherwise it holds its last value.
  - out_valid = S3 valid.
- Table contents: entry k = round((2^(AMP_W-1)-1) * sin(pi/2 * (k+0.5) / 2^LUT_AW)), for k = 0 .. 2^LUT_AW-1.
  - The half-step offset makes the mirror exact and keeps every entry ≤ 2^(AMP_W-1)-1.
  - Negation therefore never overflows. Output range is ±2047 for the defaults; -2048 never occurs.
- Quadrant mapping:
  - q = 0: rising positive.
  - q = 1: falling positive (mirrored).
  - q = 2: falling negative.
  - q = 3: rising negative (mirrored, negated).
- in_valid low: the sample is dropped. The valid bubble propagates and out_valid is low 4 cycles later; no other effect.
- Truncation: the lower PHASE_W-LUT_AW-2 phase bits are ignored. There is no dithering or interpolation.
- Offset timing: a phase_offset change affects only samples accepted on or after the cycle it is presented. There is no glitch on in-flight samples.

Decomposition:
- Package dds_pkg:
  - PHASE_W, LUT_AW, AMP_W constants.
  - Quadrant type (2-bit enum: Q_RISE_POS, Q_FALL_POS, Q_FALL_NEG, Q_RISE_NEG).
  - Table-generation function quarter_sine(k), so the ROM initialisation and the bench model share one formula.
- One sub-module: sine_quarter_rom.
  - 2^LUT_AW x (AMP_W-1) unsigned.
  - Registered read, no reset on the data array.
  - Initialised from quarter_sine; must infer block RAM/ROM.

Test Plan:
- Single sample checks, offset = 0, in_valid pulsed once (each must appear 4 cycles later with out_valid = 1 for one cycle):
  - phase_in = 0x0000000 -> sine_out = +6.
  - phase_in = 0x4000000 -> sine_out = +2047.
  - phase_in = 0x8000000 -> sine_out = -6.
  - phase_in = 0xC000000 -> sine_out = -2047.
- Offset wrap: phase_in = 0xC000000, phase_offset = 0x4000000 -> sum wraps to 0 -> sine_out = +6 after 4 cycles. Same phase_in with offset = 0x8000000 -> +2047.
- Continuous sweep: in_valid = 1, phase_in incremented by 0x40000 (one table step) per cycle for 1024 cycles. Output must match the dds_pkg model sample-for-sample:
  - one output per cycle;
  - symmetry: sample[n] = sample[511-n] for n < 512, and sample[n+512] = -sample[n];
  - never -2048.
- Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid reproduces 1,0,1,1,0 delayed by 4 cycles. sine_out holds during the 0 cycles.
- Reset mid-stream: continuous sweep, pull reset low for 2 cycles at cycle 10:
  - out_valid = 0 and sine_out = 0 immediately (asynchronous);
  - after release, out_valid stays 0 for 4 cycles, then the sweep resumes matching the model.
- Truncation: phase_in = 0x003FFFF and 0x0000000 -> identical output (+6). phase_in = 0x0040000 -> next entry (k = 1, +19).
